// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared core package for the instruction fetch slice.
//   fetch_state_e      : fetch FSM states (request / waiting / holding)
//   NOP_INSTR_DEFAULT  : default bubble encoding placed into IF/ID
//   RESET_PC_DEFAULT   : default first fetch address after reset
//   pc_next_word       : 32-bit modular pc + 4
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // Wraps naturally at 32 bits: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
    function automatic logic [31:0] pc_next_word(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with explicit control priority:
//   reset > i_flush (bubble) > i_load (new instruction) > i_hold (keep)
//   and a bubble when none of them is asserted.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_load              : capture i_instr / i_pc4 as a valid instruction
//   i_flush             : force a bubble
//   i_hold              : keep the current contents
//   i_instr, i_pc4      : instruction and fetch address + 4 to capture
//   o_instr, o_pc4      : registered instruction / address + 4
//   o_valid             : registered instruction is real (not a bubble)
// ---------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_hold,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end else if (!i_hold) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage with a single outstanding memory request, a
// one-entry hold buffer for responses that arrive while the pipeline is
// stalled, and branch redirect that discards in-flight responses.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   stall_fetch                : hold pc, issue no new request
//   stall_decode               : hold IF/ID contents
//   branch_taken/branch_target : redirect strobe and address (bits [1:0] ignored)
//   imem_req/imem_addr         : request valid / word address (= pc)
//   imem_ready                 : request accepted this cycle
//   imem_valid/imem_rdata      : response strobe / instruction
//   if_id_instr/pc4/valid      : IF/ID register outputs
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_hold_buf;
    logic        r_discard;

    logic        w_stall_any;
    logic        w_resp;
    logic        w_resp_live;
    logic        w_imem_req;
    logic        w_load;
    logic [31:0] w_load_instr;
    logic [31:0] w_pc4;
    logic [31:0] w_target;

    assign w_stall_any = stall_fetch | stall_decode;
    assign w_pc4       = pc_next_word(r_pc);
    assign w_target    = branch_target & 32'hFFFF_FFFC;
    // A response only counts while waiting; a discarded one is dropped.
    assign w_resp      = (r_state == S_WAIT) && imem_valid;
    assign w_resp_live = w_resp && !r_discard;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (branch_taken) begin
            // A redirect with the response still in flight must keep waiting
            // for it so it can be thrown away; otherwise refetch immediately.
            w_state_next = (r_state == S_WAIT && !imem_valid) ? S_WAIT : S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_imem_req && imem_ready) begin
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        if (r_discard || !w_stall_any) begin
                            w_state_next = S_REQ;
                        end else begin
                            w_state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_stall_any) begin
                        w_state_next = S_REQ;
                    end
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        w_imem_req   = (r_state == S_REQ) && !stall_fetch && !branch_taken && !reset;
        w_load       = !branch_taken && !w_stall_any &&
                       (w_resp_live || (r_state == S_HOLD));
        w_load_instr = (r_state == S_HOLD) ? r_hold_buf : imem_rdata;
    end

    // ---------------- pc / discard / hold buffer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_hold_buf <= 32'd0;
        end else if (branch_taken) begin
            r_pc       <= w_target;
            r_hold_buf <= 32'd0;
            if (r_state == S_WAIT) begin
                // Response still to come: remember to drop it.
                r_discard <= !imem_valid;
            end
        end else begin
            if (w_load) begin
                r_pc <= w_pc4;
            end
            if (w_resp) begin
                r_discard <= 1'b0;
            end
            if (w_resp_live && w_stall_any) begin
                r_hold_buf <= imem_rdata;
            end
        end
    end

    assign imem_req  = w_imem_req;
    assign imem_addr = r_pc;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (branch_taken),
        .i_hold  (stall_decode),
        .i_instr (w_load_instr),
        .i_pc4   (w_pc4),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the encoding driven into IF/ID on a bubble.
REQ-003 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 stall_fetch  input  1  SHALL mean hold the PC and issue no new request; comes from hazard detection.
REQ-006 stall_decode  input  1  SHALL mean hold the IF/ID register contents; comes from hazard detection.
REQ-007 branch_taken  input  1  SHALL be a redirect strobe from execute.
REQ-008 branch_target  input  32  SHALL be the redirect address; bits [1:0] are ignored and forced to 0.
REQ-009 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-010 imem_addr  output  32  SHALL be the request word address, equal to pc.
REQ-011 imem_ready  input  1  SHALL mean the request is accepted this cycle.
REQ-012 imem_valid  input  1  SHALL mean the response data is valid this cycle.
REQ-013 imem_rdata  input  32  SHALL be the response instruction.
REQ-014 if_id_instr  output  32  SHALL be the registered instruction to decode.
REQ-015 if_id_pc4  output  32  SHALL be the registered fetch address + 4.
REQ-016 if_id_valid  output  1  SHALL be high when if_id_instr is a real instruction.

Function
REQ-017 FSM SHALL have states REQ, WAIT and HOLD; at most one request SHALL be outstanding.
REQ-018 imem_req SHALL be driven combinationally as state==REQ && !stall_fetch && !branch_taken && !reset.
REQ-019 In REQ, imem_req && imem_ready SHALL move to WAIT; otherwise the FSM stays in REQ with pc unchanged.
REQ-020 In WAIT, imem_valid with the discard flag set SHALL clear the flag, drop the data and return to REQ.
REQ-021 In WAIT, imem_valid with !stall_fetch && !stall_decode SHALL load IF/ID {rdata, pc+4, valid=1}, set pc to pc+4 and return to REQ, giving 1-cycle response-to-IF/ID latency.
REQ-022 In WAIT, imem_valid with either stall high SHALL capture rdata in the hold buffer and move to HOLD.
REQ-023 In HOLD, !stall_fetch && !stall_decode SHALL load IF/ID from the hold buffer, set pc to pc+4 and move to REQ; otherwise the FSM stays in HOLD.
REQ-024 When stall_decode=1 and there is no redirect, IF/ID SHALL hold its value unchanged.
REQ-025 When stall_decode=0 and no instruction is loaded this cycle, IF/ID SHALL become a bubble {NOP_INSTR, 0, valid=0}.
REQ-026 branch_taken SHALL have priority over both stalls. It SHALL set pc to {branch_target[31:2], 2'b00}, set IF/ID to a bubble and move the FSM to REQ.
REQ-027 branch_taken in WAIT without imem_valid SHALL set the discard flag and keep the FSM in WAIT; the late response is then dropped.
REQ-028 branch_taken in WAIT with imem_valid in the same cycle SHALL drop that response.
REQ-029 branch_taken in HOLD SHALL drop the hold buffer.
REQ-030 pc+4 SHALL be 32-bit modular, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-031 imem_valid arriving in REQ or HOLD SHALL be ignored.

Reset
REQ-032 On reset, pc SHALL be RESET_PC, the state REQ, the discard flag 0, the hold buffer 0 and IF/ID {NOP_INSTR, 0, 0}; imem_req SHALL be 0 during reset.
REQ-033 Reset asserted mid-WAIT SHALL abandon the outstanding request, and the next response SHALL be ignored because the FSM is in REQ.

Structure
REQ-034 The state enum (REQ, WAIT, HOLD) and the default NOP_INSTR constant SHALL live in the shared core package.
REQ-035 The IF/ID register SHALL be a sub-module if_id_reg with load, flush and hold controls; it is instantiated once per core.

Verification
REQ-036 Release reset with imem_ready=1 and imem_valid one cycle after acceptance -> addresses 0x0, 0x4, 0x8 are issued, and IF/ID shows each instruction with valid=1 the cycle after its response.
REQ-037 Assert stall_fetch=stall_decode=1 for 3 cycles while a response for 0x8 arrives -> FSM enters HOLD, IF/ID is unchanged and imem_req=0; after release, the 0x8 instruction loads and the next request is 0xC.
REQ-038 Pulse branch_taken with target 0x103 while in WAIT -> the late response is discarded, the next imem_addr=0x100 and IF/ID valid=0.
REQ-039 branch_taken in the same cycle as stall_decode=1 and imem_valid -> the bubble is loaded, the response is dropped and pc=target.
REQ-040 Set pc to 0xFFFF_FFFC via branch, then fetch -> the next imem_addr=0x0000_0000 and if_id_pc4=0x0.
REQ-041 Assert reset during WAIT, then deliver imem_valid -> the response is ignored, IF/ID valid=0 and the first request goes to RESET_PC.
